// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: direct-mapped BTB with 2-bit counters, next-PC select and mispredict redirect
module branch_pred_ctrl #(
  parameter int ENTRIES = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] cpc,
  input  logic [31:0] pc4,
  output logic [31:0] npc,
  output logic        phit,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic [31:0] res_pnpc,
  output logic        flush,
  output logic        busy
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;
  typedef enum logic {NORMAL, REDIRECT} state_t;
  state_t            state_q, state_d;
  logic [31:0]       redir_q, redir_d;
  logic              valid_q [ENTRIES];
  logic [TW-1:0]     tag_q   [ENTRIES];
  logic [29:0]       tgt_q   [ENTRIES];
  logic [1:0]        cnt_q   [ENTRIES];
  logic [IW-1:0]     lidx, ridx;
  logic              lhit, rhit, mispredict;
  logic [31:0]       actual;
  logic              unused_ok;
  assign unused_ok  = ^{cpc[1:0], res_pc[1:0], res_target[1:0]};
  assign lidx       = cpc[IW+1:2];
  assign ridx       = res_pc[IW+1:2];
  assign lhit       = valid_q[lidx] && tag_q[lidx] == cpc[31:IW+2];
  assign rhit       = valid_q[ridx] && tag_q[ridx] == res_pc[31:IW+2];
  assign phit       = lhit & cnt_q[lidx][1];
  assign actual     = res_taken ? res_target : res_pc + 32'd4;
  assign mispredict = res_valid && actual != res_pnpc;
  always_comb begin
    state_d = state_q;
    redir_d = redir_q;
    flush   = 1'b0;
    busy    = 1'b0;
    npc     = phit ? {tgt_q[lidx], 2'b00} : pc4;
    if (state_q == REDIRECT) begin
      flush = 1'b1;
      busy  = 1'b1;
      npc   = redir_q;
      state_d = ihit ? NORMAL : REDIRECT;
    end else if (mispredict) begin
      flush = 1'b1;
      npc   = actual;
      if (!ihit) begin
        redir_d = actual;
        state_d = REDIRECT;
      end
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= NORMAL;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      redir_q <= redir_d;
    end
  end
  // Table writes land on the edge, so a same-cycle lookup sees the old entry.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= 2'b01;
      end
    end else if (res_valid) begin
      if (rhit) begin
        cnt_q[ridx] <= res_taken ? (cnt_q[ridx] == 2'b11 ? 2'b11 : cnt_q[ridx] + 2'b01)
                                 : (cnt_q[ridx] == 2'b00 ? 2'b00 : cnt_q[ridx] - 2'b01);
        if (res_taken) tgt_q[ridx] <= res_target[31:2];
      end else if (res_taken) begin
        valid_q[ridx] <= 1'b1;
        tag_q[ridx]   <= res_pc[31:IW+2];
        tgt_q[ridx]   <= res_target[31:2];
        cnt_q[ridx]   <= 2'b10;
      end
    end
  end
endmodule
